ultrasonic_scan_scheduler: RTL and testbench

- Time-multiplexes one trigger/echo measurement engine across N ultrasonic sensors in round-robin order.
- Per enabled sensor: issues a trigger pulse, waits for the echo rising edge, counts the echo high time in clk cycles, posts a one-cycle result, then holds off before the next sensor.
- Sits between the sensor pins and downstream distance/LED logic, replacing per-sensor free-running trigger FSMs.

---
 rtl/ultrasonic_pkg.sv | 24 ++
 rtl/ultrasonic_scan_scheduler_echo_conditioner.sv | 48 ++++
 rtl/ultrasonic_scan_scheduler.sv | 122 ++++++++++++
 tb/tb_ultrasonic_scan_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: scan state encoding, default timing constants and round-robin sensor pick
package ultrasonic_pkg;
  typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_ECHO, MEASURE, REPORT, HOLDOFF} scan_state_t;
  localparam int unsigned DEF_NUM_SENSORS = 4;
  localparam int unsigned DEF_TRIG_CYCLES = 270;
  localparam int unsigned DEF_ECHO_TIMEOUT = 1000000;
  localparam int unsigned DEF_MAX_WIDTH = 1000000;
  localparam int unsigned DEF_GAP_CYCLES = 1620000;
  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_FILTER_LEN = 4;
  // lowest set bit of mask at or after start, wrapping at n; start when mask is empty
  function automatic int unsigned next_enabled(input logic [31:0] mask, input int unsigned start,
                                               input int unsigned n);
    int unsigned j, idx, r;
    r = start;
    for (int k = 0; k < 32; k++) begin
      j = 32'(31 - k);
      idx = start + j;
      idx = (idx >= n) ? idx - n : idx;
      if (j < n && mask[idx[4:0]]) r = idx;
    end
    return r;
  endfunction
endpackage

// File: rtl/ultrasonic_scan_scheduler_echo_conditioner.sv
// echo_conditioner: synchronizes the muxed echo, optionally debounces it (ULTRASONIC_ECHO_FILTER_EN),
// and emits rise/fall pulses of the resulting level.
module echo_conditioner #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic echo,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= echo;
      s2 <= s1;
      prev <= level;
    end
  end
`ifdef ULTRASONIC_ECHO_FILTER_EN
  logic [$clog2(FILTER_LEN + 1)-1:0] fcnt;
  logic filt;
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == ($bits(fcnt))'(FILTER_LEN - 1)) begin
      filt <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end
  assign level = filt;
`else
  assign level = s2;
`endif
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler: round-robin trigger/echo measurement over NUM_SENSORS sensors.
// Optional echo debounce filter enabled by ULTRASONIC_ECHO_FILTER_EN.
module ultrasonic_scan_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = DEF_NUM_SENSORS,
  parameter int unsigned TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int unsigned ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
  parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  localparam int unsigned ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [NUM_SENSORS-1:0] en_mask,
  input  logic [NUM_SENSORS-1:0] echo_pin,
  output logic [NUM_SENSORS-1:0] trigger_pin,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic [CNT_W-1:0]       res_width,
  output logic                   res_timeout,
  output logic                   busy
);
  scan_state_t state, state_n;
  logic [ID_W-1:0] sel, sel_n, ptr, ptr_n, wrap, pick_ptr, pick_wrap;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic tmo, tmo_n, armed, armed_n, level, rise, fall, go;
  assign go = run && |en_mask;
  assign wrap = (sel == ID_W'(NUM_SENSORS - 1)) ? '0 : sel + 1'b1;
  assign pick_ptr = ID_W'(next_enabled(32'(en_mask), 32'(ptr), NUM_SENSORS));
  assign pick_wrap = ID_W'(next_enabled(32'(en_mask), 32'(wrap), NUM_SENSORS));
  assign busy = state != IDLE;
  echo_conditioner #(.FILTER_LEN(FILTER_LEN)) u_cond (
    .clk(clk), .rst(rst), .clr(sel_n != sel), .echo(echo_pin[sel]),
    .level(level), .rise(rise), .fall(fall)
  );
  always_comb begin
    state_n = state;
    sel_n = sel;
    ptr_n = ptr;
    cnt_n = cnt;
    tmo_n = tmo;
    armed_n = 1'b0;
    unique case (state)
      IDLE: if (go) begin
        state_n = TRIGGER;
        sel_n = pick_ptr;
        cnt_n = '0;
      end
      TRIGGER: begin
        state_n = (cnt == CNT_W'(TRIG_CYCLES - 1)) ? WAIT_ECHO : TRIGGER;
        cnt_n = (cnt == CNT_W'(TRIG_CYCLES - 1)) ? '0 : cnt + 1'b1;
      end
      // a rise only counts once a low level has been seen here, so a stuck-high echo is ignored
      WAIT_ECHO: begin
        armed_n = armed | ~level;
        if (rise && armed) begin
          state_n = MEASURE;
          cnt_n = CNT_W'(1);
        end else if (cnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
          state_n = REPORT;
          cnt_n = '0;
          tmo_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      MEASURE: begin
        if (fall) begin
          state_n = REPORT;
          tmo_n = 1'b0;
        end else if (cnt == CNT_W'(MAX_WIDTH)) begin
          state_n = REPORT;
          tmo_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      REPORT: begin
        state_n = HOLDOFF;
        cnt_n = '0;
      end
      HOLDOFF: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          ptr_n = wrap;
          cnt_n = '0;
          state_n = go ? TRIGGER : IDLE;
          sel_n = go ? pick_wrap : sel;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sel <= '0;
      ptr <= '0;
      cnt <= '0;
      tmo <= 1'b0;
      armed <= 1'b0;
      trigger_pin <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_width <= '0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      tmo <= tmo_n;
      armed <= armed_n;
      trigger_pin <= (state_n == TRIGGER) ? NUM_SENSORS'(1) << sel_n : '0;
      res_valid <= state == REPORT;
      if (state == REPORT) begin
        res_id <= sel;
        res_width <= cnt;
        res_timeout <= tmo;
      end
    end
  end
endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb_ultrasonic_scan_scheduler: directed scan scenarios with an echo responder driving the sensor pins
module tb_ultrasonic_scan_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic [3:0] en_mask = '0;
  logic [3:0] echo_pin = '0;
  logic [3:0] trigger_pin;
  logic res_valid, res_timeout, busy;
  logic [1:0] res_id;
  logic [31:0] res_width;
  int total = 0;
  int bad = 0;
  int pw [4];
  int glitch = 0;
  int rid;
  int lat;
  logic [3:0] trig_d = '0;

  always #5 clk = ~clk;

  ultrasonic_scan_scheduler #(
    .NUM_SENSORS(4), .TRIG_CYCLES(4), .ECHO_TIMEOUT(50), .MAX_WIDTH(100),
    .GAP_CYCLES(10), .CNT_W(32), .FILTER_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .en_mask(en_mask), .echo_pin(echo_pin),
    .trigger_pin(trigger_pin), .res_valid(res_valid), .res_id(res_id),
    .res_width(res_width), .res_timeout(res_timeout), .busy(busy)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sensor model: 3 cycles after its trigger falls, optional glitch, then a pw-cycle echo
  initial begin
    forever begin
      @(negedge clk);
      rid = -1;
      for (int k = 0; k < 4; k++) if (trig_d[k] && !trigger_pin[k]) rid = k;
      trig_d = trigger_pin;
      if (rid >= 0 && pw[rid] > 0) begin
        repeat (3) @(negedge clk);
        if (glitch > 0) begin
          echo_pin[rid] = 1'b1;
          repeat (glitch) @(negedge clk);
          echo_pin[rid] = 1'b0;
          repeat (6) @(negedge clk);
        end
        echo_pin[rid] = 1'b1;
        repeat (pw[rid]) @(negedge clk);
        echo_pin[rid] = 1'b0;
      end
    end
  end

  task automatic wait_trig(string tag, logic [3:0] exp);
    int n = 0;
    while (trigger_pin == 4'd0 && n < 2000) begin @(negedge clk); n++; end
    check(tag, trigger_pin, exp);
    n = 0;
    while (trigger_pin != 4'd0 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_len"}, n, 4);
  endtask

  task automatic wait_res(string tag, int id, int w, int to, output int n);
    n = 0;
    while (!res_valid && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_id"}, res_id, id);
    check({tag, "_width"}, res_width, w);
    check({tag, "_timeout"}, res_timeout, to);
    @(negedge clk);
    check({tag, "_strobe"}, res_valid, 0);
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    run = 1'b0;
    while ((busy || echo_pin != 4'd0) && n < 1000) begin @(negedge clk); n++; end
    check(tag, busy, 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) pw[k] = 20;
    repeat (3) @(negedge clk);
    check("rst_trig", trigger_pin, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_width", res_width, 0);
    check("rst_id", res_id, 0);
    check("rst_timeout", res_timeout, 0);
    rst = 1'b1;
    // round robin over sensors 0 and 2
    en_mask = 4'b0101;
    run = 1'b1;
    wait_trig("rr_t0", 4'b0001);
    wait_res("rr_r0", 0, 20, 0, lat);
    wait_trig("rr_t2", 4'b0100);
    wait_res("rr_r2", 2, 20, 0, lat);
    wait_trig("rr_t0b", 4'b0001);
    wait_res("rr_r0b", 0, 20, 0, lat);
    wait_idle("rr_idle");
    // no echo: 50 WAIT_ECHO cycles, then REPORT, strobe one cycle later
    pw[1] = 0;
    en_mask = 4'b0010;
    run = 1'b1;
    wait_trig("to_t1", 4'b0010);
    wait_res("to_r1", 1, 0, 1, lat);
    check("to_latency", lat, 51);
    wait_idle("to_idle");
    // stuck-high echo saturates, and the following scan must not count the held level
    pw[1] = 200;
    run = 1'b1;
    wait_trig("sat_t1", 4'b0010);
    wait_res("sat_r1", 1, 100, 1, lat);
    pw[1] = 0;
    wait_trig("sat_t1b", 4'b0010);
    wait_res("sat_r1b", 1, 0, 1, lat);
    wait_idle("sat_idle");
    // run dropped during MEASURE: result still posted, idle after the 10-cycle holdoff
    pw[0] = 30;
    en_mask = 4'b0001;
    run = 1'b1;
    wait_trig("drop_t0", 4'b0001);
    lat = 0;
    while (!echo_pin[0] && lat < 100) begin @(negedge clk); lat++; end
    repeat (5) @(negedge clk);
    run = 1'b0;
    wait_res("drop_r0", 0, 30, 0, lat);
    repeat (8) @(negedge clk);
    check("drop_busy_hold", busy, 1);
    @(negedge clk);
    check("drop_busy_end", busy, 0);
    repeat (5) @(negedge clk);
    check("drop_no_trig", trigger_pin, 0);
    // reset during TRIGGER of sensor 1 restarts the scan from sensor 0
    pw[0] = 20;
    en_mask = 4'b1111;
    run = 1'b1;
    lat = 0;
    while (trigger_pin == 4'd0 && lat < 100) begin @(negedge clk); lat++; end
    check("mrst_pre", trigger_pin, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_trig", trigger_pin, 0);
    check("mrst_busy", busy, 0);
    check("mrst_valid", res_valid, 0);
    check("mrst_width", res_width, 0);
    check("mrst_id", res_id, 0);
    check("mrst_timeout", res_timeout, 0);
    wait_trig("mrst_t0", 4'b0001);
    wait_res("mrst_r0", 0, 20, 0, lat);
    wait_idle("mrst_idle");
    // 2-cycle glitch then a 25-cycle echo
    glitch = 2;
    pw[0] = 25;
    en_mask = 4'b0001;
    run = 1'b1;
    wait_trig("glt_t0", 4'b0001);
`ifdef ULTRASONIC_ECHO_FILTER_EN
    wait_res("glt_r0", 0, 25, 0, lat);
`else
    wait_res("glt_r0", 0, 2, 0, lat);
`endif
    wait_idle("glt_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
